fsm_rr_arbiter: RTL and testbench

Moore-type round-robin arbiter that shares a single downstream resource (for example an FSM-driven datapath) between N requesters. It grants exactly one requester at a time and holds the grant until the owner signals done, drops its request, or exceeds a hold-time limit. Between any two grants there is one mandatory dead cycle. All outputs are decoded from registered state only.

---
 rtl/fsm_rr_arbiter.sv | 117 +++++++++++
 tb/tb_fsm_rr_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// Moore round-robin arbiter: one grant at a time, held until done, request drop or
// hold-time limit, with one mandatory dead cycle between grants.
module fsm_rr_arbiter #(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 16,
    localparam int IDW     = $clog2(N),
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_REL   = 2'd2,
        S_TOUT  = 2'd3
    } state_t;

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [N-1:0]   ONE      = N'(1);

    state_t         state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] winner;
    logic [CW-1:0]  cnt;

    // Cyclic search starting just above the previous winner, so the last owner ranks lowest.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] l);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = l;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(l) + i;
            if (idx >= N) idx = idx - N;
            if (!found && r[idx[IDW-1:0]]) begin
                w     = idx[IDW-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb winner = pick(req, last);

    // gnt_id doubles as the owner register; outputs are loaded together with the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            last    <= IDW'(N - 1);
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state   <= S_GRANT;
                        gnt     <= ONE << winner;
                        gnt_id  <= winner;
                        last    <= winner;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                    if (done || !req[gnt_id]) begin
                        state   <= S_REL;
                        gnt     <= '0;
                        timeout <= 1'b0;
                    end else if (TO_EN && cnt == CNT_LAST) begin
                        state   <= S_TOUT;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end
                end
                S_REL, S_TOUT: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state  <= S_GRANT;
                        gnt    <= ONE << winner;
                        gnt_id <= winner;
                        last   <= winner;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed vector bench for fsm_rr_arbiter (N=4, TIMEOUT=16): table of
// {req, done -> gnt, gnt_id, busy, timeout} plus hand sequences for timeout and reset.
module tb_fsm_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       tout;
    } vec_t;

    vec_t tbl[$];

    fsm_rr_arbiter #(.N(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d required=completion", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
        vectors++;
        if (gnt !== eg || gnt_id !== eid || busy !== eb || timeout !== et) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b tout=%b, expected gnt=%b id=%0d busy=%b tout=%b",
                     name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_defaults", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // single requester, done in 3rd grant cycle, re-grant, drop to idle
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0});
        // fairness with wrap, last owner = 2: order 3,0,1,2,3
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
        // owner 3 drops request while req[0] pending
        tbl.push_back('{4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
        // non-owner request ignored during grant
        tbl.push_back('{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
        // done in idle is ignored
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].tout);
        end

        // timeout: 16 grant cycles, one S_TOUT cycle, then re-grant to 1
        for (int i = 0; i < 16; i++) begin
            step(4'b0010, 1'b0);
            check($sformatf("tout_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(4'b0010, 1'b0);
        check("tout_pulse", 4'b0000, 2'd1, 1'b1, 1'b1);
        step(4'b0010, 1'b0);
        check("tout_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done on the same edge as cnt==TIMEOUT-1: release without timeout
        for (int i = 0; i < 15; i++) begin
            step(4'b0010, 1'b0);
            check($sformatf("simul_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(4'b0010, 1'b1);
        check("simul_rel", 4'b0000, 2'd1, 1'b1, 1'b0);
        step(4'b0000, 1'b0);
        check("simul_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // async reset between edges during a grant
        step(4'b0100, 1'b0);
        check("pre_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        req  = '0;
        rst  = 1'b1;
        #1;
        check("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // after reset index 0 wins first: order 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            logic [1:0] e;
            e = 2'(k % 4);
            step(4'b1111, 1'b0);
            check($sformatf("post_rst_gnt%0d", k), 4'b0001 << e, e, 1'b1, 1'b0);
            step(4'b1111, 1'b1);
            check($sformatf("post_rst_rel%0d", k), 4'b0000, e, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
